// File: rtl/prompt_pkg.sv
// Shared types and constants for the memory-game prompt sequencer.
package prompt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_APPEND     = 3'd1,
        ST_SHOW_ON    = 3'd2,
        ST_SHOW_OFF   = 3'd3,
        ST_WAIT_INPUT = 3'd4,
        ST_PASS       = 3'd5,
        ST_FAIL       = 3'd6
    } state_t;

    localparam logic [2:0] PROMPT_NONE   = 3'd0;
    localparam logic [2:0] PROMPT_TOGGLE = 3'd1;
    localparam logic [2:0] PROMPT_PUSH   = 3'd2;
    localparam logic [2:0] PROMPT_MIC    = 3'd3;
    localparam logic [2:0] PROMPT_MOUSE  = 3'd4;

    localparam logic [1:0] CODE_TOGGLE = 2'd0;
    localparam logic [1:0] CODE_PUSH   = 2'd1;
    localparam logic [1:0] CODE_MIC    = 2'd2;
    localparam logic [1:0] CODE_MOUSE  = 2'd3;

    // Prompt LEDs reserve 0 for blank, so every input code is shown offset by one.
    function automatic logic [2:0] code_to_prompt(input logic [1:0] code);
        return {1'b0, code} + 3'd1;
    endfunction

endpackage

// File: rtl/prompt_lfsr.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); exposes the two
// low bits as the next random input code.
module prompt_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [1:0] rand_code
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       feedback;

    // Shift left, feeding back the tapped bits into bit 0.
    always_comb begin
        feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d   = {lfsr_q[6:0], feedback};
    end

    // State register, reloaded with SEED while reset is low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rand_code = lfsr_q[1:0];

endmodule

// File: rtl/prompt_sequencer.sv
// Round sequencer: grows a random prompt sequence by one element per level,
// replays it on the prompt LEDs, then checks the player's echo element by element.
module prompt_sequencer
    import prompt_pkg::*;
#(
    parameter int         MAX_LEN    = 16,
    parameter int         ON_CYCLES  = 25000000,
    parameter int         OFF_CYCLES = 12500000,
    parameter int         TIMEOUT    = 250000000,
    parameter logic [7:0] SEED       = 8'hA5
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           retry,
    input  logic                           clear,
    input  logic                           user_valid,
    input  logic [1:0]                     user_code,
    output logic [2:0]                     prompt,
    output logic                           busy,
    output logic                           awaiting_input,
    output logic                           round_pass,
    output logic                           round_fail,
    output logic [$clog2(MAX_LEN+1)-1:0]   level,
    output logic                           seq_full
);

    localparam int LW   = $clog2(MAX_LEN + 1);
    localparam int IW   = $clog2(MAX_LEN);
    localparam int TMX1 = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMAX = (TMX1 > TIMEOUT) ? TMX1 : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] ON_LAST   = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(OFF_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(MAX_LEN);

    state_t        state_q, state_d;
    logic [LW-1:0] level_q, level_d;
    logic [IW-1:0] index_q, index_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    prompt_q, prompt_d;
    logic          busy_q, busy_d;
    logic          awaiting_q, awaiting_d;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          seq_full_q, seq_full_d;

    logic [1:0]    seq_q [MAX_LEN];
    logic          seq_we;
    logic [1:0]    rand_code;
    logic [1:0]    cur_code;
    logic          at_last;

    prompt_lfsr #(.SEED(SEED)) u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .rand_code (rand_code)
    );

    assign cur_code = seq_q[index_q];
    assign at_last  = (LW'(index_q) == (level_q - LW'(1)));

    // Next-state logic; clear overrides everything and empties the sequence.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        index_d = index_q;
        timer_d = timer_q;
        seq_we  = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            level_d = '0;
            index_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    index_d = '0;
                    timer_d = '0;
                    if (start) begin
                        state_d = (level_q == LEVEL_MAX) ? ST_SHOW_ON : ST_APPEND;
                    end else if (retry && (level_q != '0)) begin
                        state_d = ST_SHOW_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_APPEND: begin
                    seq_we  = 1'b1;
                    level_d = level_q + LW'(1);
                    index_d = '0;
                    timer_d = '0;
                    state_d = ST_SHOW_ON;
                end
                ST_SHOW_ON: begin
                    if (timer_q == ON_LAST) begin
                        timer_d = '0;
                        state_d = ST_SHOW_OFF;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_SHOW_OFF: begin
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        if (at_last) begin
                            index_d = '0;
                            state_d = ST_WAIT_INPUT;
                        end else begin
                            index_d = index_q + IW'(1);
                            state_d = ST_SHOW_ON;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_WAIT_INPUT: begin
                    // An input event in the same cycle as the timeout still counts.
                    if (user_valid) begin
                        timer_d = '0;
                        if (user_code != cur_code) begin
                            state_d = ST_FAIL;
                        end else if (at_last) begin
                            state_d = ST_PASS;
                        end else begin
                            index_d = index_q + IW'(1);
                        end
                    end else if (TIMEOUT == 0) begin
                        timer_d = '0;
                    end else if (timer_q == TO_LAST) begin
                        timer_d = '0;
                        state_d = ST_FAIL;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_PASS, ST_FAIL: begin
                    index_d = '0;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode, registered one cycle behind the state so prompt cannot glitch.
    always_comb begin
        prompt_d   = PROMPT_NONE;
        busy_d     = 1'b0;
        awaiting_d = 1'b0;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        seq_full_d = (level_d == LEVEL_MAX);
        if (clear) begin
            prompt_d   = PROMPT_NONE;
            busy_d     = 1'b0;
        end else begin
            prompt_d   = (state_q == ST_SHOW_ON) ? code_to_prompt(cur_code) : PROMPT_NONE;
            busy_d     = (state_q != ST_IDLE);
            awaiting_d = (state_q == ST_WAIT_INPUT);
            pass_d     = (state_q == ST_PASS);
            fail_d     = (state_q == ST_FAIL);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            index_q    <= '0;
            timer_q    <= '0;
            prompt_q   <= PROMPT_NONE;
            busy_q     <= 1'b0;
            awaiting_q <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            seq_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            index_q    <= index_d;
            timer_q    <= timer_d;
            prompt_q   <= prompt_d;
            busy_q     <= busy_d;
            awaiting_q <= awaiting_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            seq_full_q <= seq_full_d;
        end
    end

    // Sequence storage; deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (seq_we) begin
            seq_q[level_q[IW-1:0]] <= rand_code;
        end
    end

    assign prompt         = prompt_q;
    assign busy           = busy_q;
    assign awaiting_input = awaiting_q;
    assign round_pass     = pass_q;
    assign round_fail     = fail_q;
    assign level          = level_q;
    assign seq_full       = seq_full_q;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Scoreboard bench for prompt_sequencer: expected prompts come from a bench-side
// LFSR model and are popped as the DUT replays them.
module tb_prompt_sequencer;

    localparam int MAX_LEN_C = 4;
    localparam int ON_C      = 4;
    localparam int OFF_C     = 2;
    localparam int TO_C      = 20;

    logic       clock;
    logic       reset;
    logic       start;
    logic       retry;
    logic       clear;
    logic       user_valid;
    logic [1:0] user_code;
    logic [2:0] prompt;
    logic       busy;
    logic       awaiting_input;
    logic       round_pass;
    logic       round_fail;
    logic [2:0] level;
    logic       seq_full;

    int checks = 0;
    int fails  = 0;

    logic [7:0] m_lfsr;
    logic [1:0] exp_seq[$];
    logic [2:0] sb_q[$];

    prompt_sequencer #(
        .MAX_LEN    (MAX_LEN_C),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .TIMEOUT    (TO_C),
        .SEED       (8'hA5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .retry          (retry),
        .clear          (clear),
        .user_valid     (user_valid),
        .user_code      (user_code),
        .prompt         (prompt),
        .busy           (busy),
        .awaiting_input (awaiting_input),
        .round_pass     (round_pass),
        .round_fail     (round_fail),
        .level          (level),
        .seq_full       (seq_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left.
    always @(posedge clock) begin
        if (!reset) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_scoreboard();
        foreach (exp_seq[i]) sb_q.push_back({1'b0, exp_seq[i]} + 3'd1);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (exp_seq.size() < MAX_LEN_C) exp_seq.push_back(m_lfsr[1:0]);
        load_scoreboard();
    endtask

    task automatic do_retry();
        retry = 1'b1;
        tick();
        retry = 1'b0;
        load_scoreboard();
    endtask

    task automatic echo_seq(input int n);
        for (int i = 0; i < n; i++) begin
            user_valid = 1'b1;
            user_code  = exp_seq[i];
            tick();
        end
        user_valid = 1'b0;
    endtask

    // Follows one replay: pops each prompt, checks widths, latency and level.
    task automatic observe_replay(input int n_el, input int lat, input int exp_lvl);
        int         first_rise;
        int         run;
        int         exp_wait;
        int         limit;
        bit         done;
        logic [2:0] prev;
        logic [2:0] exp_p;
        first_rise = -1;
        run        = 0;
        done       = 1'b0;
        prev       = 3'd0;
        exp_wait   = lat + n_el * (ON_C + OFF_C);
        limit      = exp_wait + 10;
        for (int cyc = 1; cyc <= limit && !done; cyc++) begin
            tick();
            if (cyc == 1) begin
                checks++;
                if (level !== 3'(exp_lvl)) begin
                    fails++;
                    $display("FAIL replay_level: got %0d, expected %0d", level, exp_lvl);
                end
            end
            if (prompt !== 3'd0) begin
                if (prev === 3'd0) begin
                    if (first_rise < 0) first_rise = cyc;
                    checks++;
                    if (sb_q.size() == 0) begin
                        fails++;
                        $display("FAIL prompt_unexpected: got %0d, expected none", prompt);
                    end else begin
                        exp_p = sb_q.pop_front();
                        if (prompt !== exp_p) begin
                            fails++;
                            $display("FAIL prompt_value: got %0d, expected %0d", prompt, exp_p);
                        end
                    end
                    run = 1;
                end else begin
                    run++;
                end
            end else if (prev !== 3'd0) begin
                checks++;
                if (run != ON_C) begin
                    fails++;
                    $display("FAIL prompt_width: got %0d cycles, expected %0d", run, ON_C);
                end
            end
            if (awaiting_input === 1'b1) begin
                done = 1'b1;
                checks++;
                if (cyc != exp_wait) begin
                    fails++;
                    $display("FAIL await_latency: got %0d, expected %0d", cyc, exp_wait);
                end
                checks++;
                if (sb_q.size() != 0) begin
                    fails++;
                    $display("FAIL prompts_missing: got %0d left, expected 0", sb_q.size());
                end
            end
            prev = prompt;
        end
        checks++;
        if (!done) begin
            fails++;
            $display("FAIL await_timeout: awaiting_input not seen in %0d cycles", limit);
        end
        checks++;
        if (first_rise != lat) begin
            fails++;
            $display("FAIL first_prompt: got cycle %0d, expected %0d", first_rise, lat);
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; retry = 1'b0; clear = 1'b0;
        user_valid = 1'b0; user_code = 2'd0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (prompt !== 3'd0 || level !== 3'd0) begin
            fails++;
            $display("FAIL reset_prompt_level: got %0d/%0d, expected 0/0", prompt, level);
        end
        checks++;
        if ({busy, awaiting_input, round_pass, round_fail, seq_full} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {busy, awaiting_input, round_pass, round_fail, seq_full});
        end
    endtask

    task automatic test_first_round();
        repeat (5) tick();
        do_start();
        observe_replay(1, 2, 1);
        echo_seq(1);
        checks++;
        if (round_pass !== 1'b0) begin
            fails++;
            $display("FAIL pass_early: got %b, expected 0", round_pass);
        end
        tick();
        checks++;
        if (round_pass !== 1'b1 || busy !== 1'b1 || round_fail !== 1'b0) begin
            fails++;
            $display("FAIL pass_pulse: got pass=%b busy=%b fail=%b, expected 1 1 0",
                     round_pass, busy, round_fail);
        end
        tick();
        checks++;
        if (round_pass !== 1'b0 || busy !== 1'b0 || level !== 3'd1) begin
            fails++;
            $display("FAIL pass_end: got pass=%b busy=%b level=%0d, expected 0 0 1",
                     round_pass, busy, level);
        end
    endtask

    task automatic test_wrong_input();
        do_start();
        observe_replay(2, 2, 2);
        echo_seq(1);
        user_valid = 1'b1;
        user_code  = exp_seq[1] ^ 2'b01;
        tick();
        user_valid = 1'b0;
        tick();
        checks++;
        if (round_fail !== 1'b1 || round_pass !== 1'b0) begin
            fails++;
            $display("FAIL wrong_fail_pulse: got fail=%b pass=%b, expected 1 0", round_fail, round_pass);
        end
        tick();
        checks++;
        if (round_fail !== 1'b0 || busy !== 1'b0 || level !== 3'd2) begin
            fails++;
            $display("FAIL wrong_end: got fail=%b busy=%b level=%0d, expected 0 0 2",
                     round_fail, busy, level);
        end
    endtask

    task automatic test_retry();
        tick();
        do_retry();
        observe_replay(2, 1, 2);
    endtask

    task automatic test_timeout();
        int k;
        k = -1;
        for (int i = 1; i <= TO_C + 5 && k < 0; i++) begin
            tick();
            if (round_fail === 1'b1) k = i;
        end
        checks++;
        if (k != TO_C) begin
            fails++;
            $display("FAIL timeout_cycles: got %0d, expected %0d", k, TO_C);
        end
        tick();
    endtask

    task automatic test_ignored_input();
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            user_valid = 1'b1;
            user_code  = 2'(i);
            tick();
            if (busy !== 1'b0 || round_pass !== 1'b0 || round_fail !== 1'b0 || level !== 3'd2)
                bad = 1'b1;
        end
        user_valid = 1'b0;
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL idle_input: got activity in IDLE, expected none");
        end
    endtask

    task automatic test_fill_to_max();
        do_retry();
        observe_replay(2, 1, 2);
        echo_seq(2);
        repeat (2) tick();
        for (int lvl = 3; lvl <= MAX_LEN_C + 1; lvl++) begin
            int eff;
            eff = (lvl > MAX_LEN_C) ? MAX_LEN_C : lvl;
            do_start();
            observe_replay(eff, (lvl > MAX_LEN_C) ? 1 : 2, eff);
            echo_seq(eff);
            tick();
            checks++;
            if (round_pass !== 1'b1) begin
                fails++;
                $display("FAIL fill_pass: got %b at level %0d, expected 1", round_pass, eff);
            end
            tick();
            checks++;
            if (level !== 3'(eff) || seq_full !== (eff == MAX_LEN_C) || busy !== 1'b0) begin
                fails++;
                $display("FAIL fill_state: got level=%0d full=%b busy=%b, expected %0d %b 0",
                         level, seq_full, busy, eff, (eff == MAX_LEN_C));
            end
        end
    endtask

    task automatic test_clear();
        int  w;
        bit  bad;
        start = 1'b1;
        tick();
        start = 1'b0;
        w = 0;
        while (prompt === 3'd0 && w < 6) begin
            tick();
            w++;
        end
        checks++;
        if (prompt === 3'd0) begin
            fails++;
            $display("FAIL clear_setup: got prompt 0, expected a shown prompt");
        end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (level !== 3'd0 || busy !== 1'b0 || prompt !== 3'd0 || seq_full !== 1'b0) begin
            fails++;
            $display("FAIL clear_now: got level=%0d busy=%b prompt=%0d full=%b, expected 0 0 0 0",
                     level, busy, prompt, seq_full);
        end
        bad = 1'b0;
        repeat (10) begin
            tick();
            if (round_pass !== 1'b0 || round_fail !== 1'b0 || busy !== 1'b0 || awaiting_input !== 1'b0)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL clear_quiet: got a pulse or busy after clear, expected none");
        end
        exp_seq.delete();
        do_start();
        observe_replay(1, 2, 1);
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_wrong_input();
        test_retry();
        test_timeout();
        test_ignored_input();
        test_fill_to_max();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/prompt_sequencer.md
Name: prompt_sequencer

Overview:
- Round sequencer for the memory game. It builds a random prompt sequence one element per level, replays it on the prompt LEDs at a fixed rate, then checks the player's echoed inputs element by element.
- Sits between the top-level game control FSM (which drives start/retry/clear and owns score and lives) and the input decode path, which delivers one-cycle coded input events.
- Replaces the shift-string display and whole-string compare with an indexed store and a per-element compare.

Parameters:
- MAX_LEN, 16, maximum sequence length (elements); power of two not required, ≥2.
- ON_CYCLES, 25000000, clock cycles each prompt is shown (≥1).
- OFF_CYCLES, 12500000, blank cycles after each prompt (≥1).
- TIMEOUT, 250000000, cycles allowed per input before fail; 0 disables timeout.
- SEED, 8'hA5, LFSR reset value (nonzero).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- start  in  1  level pulse: append one element (if not full) then replay.
- retry  in  1  pulse: replay the current sequence without appending.
- clear  in  1  pulse: abort and empty the sequence.
- user_valid  in  1  one-cycle input event strobe.
- user_code  in  2  input id: 0 toggle, 1 push, 2 mic, 3 mouse.
- prompt  out  3  0 blank, else user_code+1 of the element being shown.
- busy  out  1  high in any state except IDLE.
- awaiting_input  out  1  high in WAIT_INPUT.
- round_pass  out  1  one-cycle pulse: full sequence echoed correctly.
- round_fail  out  1  one-cycle pulse: wrong input or timeout.
- level  out  $clog2(MAX_LEN+1)  current sequence length.
- seq_full  out  1  level == MAX_LEN.

Behaviour:
- Reset: state IDLE; prompt, busy, awaiting_input, round_pass, round_fail, level and seq_full all 0; LFSR = SEED; index and timers 0. The storage array is not cleared.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Free-runs every cycle outside reset. New element = lfsr[1:0], sampled in APPEND.
- States and transitions:
  - IDLE → APPEND on start when not full.
  - IDLE → SHOW_ON on start when full.
  - IDLE → SHOW_ON on retry when level > 0; retry with level 0 is ignored.
  - start and retry in the same cycle: start wins.
  - APPEND: write seq[level] = lfsr[1:0], level += 1, index = 0 → SHOW_ON.
  - SHOW_ON: prompt = seq[index]+1 for ON_CYCLES cycles → SHOW_OFF.
  - SHOW_OFF: prompt = 0 for OFF_CYCLES cycles. Then if index == level-1: index = 0 → WAIT_INPUT; else index += 1 → SHOW_ON.
  - WAIT_INPUT, user_valid with user_code == seq[index]: if index == level-1 → PASS, else index += 1 and restart the timeout timer.
  - WAIT_INPUT, user_valid with a mismatching code → FAIL.
  - WAIT_INPUT, timeout timer reaches TIMEOUT with no user_valid → FAIL.
  - PASS: round_pass = 1 for one cycle → IDLE.
  - FAIL: round_fail = 1 for one cycle → IDLE. level is unchanged, so a retry replays the identical sequence.
- Latency: if start is sampled in IDLE at edge n, the first prompt is visible from cycle n+2. The replay phase lasts level×(ON_CYCLES+OFF_CYCLES) cycles. awaiting_input rises at n+2+level×(ON+OFF).
- Ignored inputs:
  - user_valid outside WAIT_INPUT.
  - start/retry outside IDLE.
- clear: from any state, next cycle goes to IDLE with level = 0 and index = 0. No round_pass or round_fail pulse is generated. clear has priority over start, retry and user_valid in the same cycle.
- A pass at level == MAX_LEN sets seq_full. After that, start replays without appending and level never exceeds MAX_LEN.
- Outputs are registered from state/counters. prompt never glitches between elements.

Decomposition:
- Shared package prompt_pkg:
  - state enum: IDLE, APPEND, SHOW_ON, SHOW_OFF, WAIT_INPUT, PASS, FAIL.
  - prompt constants: PROMPT_NONE=0, PROMPT_TOGGLE=1, PROMPT_PUSH=2, PROMPT_MIC=3, PROMPT_MOUSE=4.
  - input code constants 0..3.
- One sub-module: prompt_lfsr (8-bit, SEED parameter, free-running, synchronous active-low reset).
- Sequence storage and FSM stay in prompt_sequencer.

Test Plan (MAX_LEN=4, ON=4, OFF=2, TIMEOUT=20):
1. Hold reset low 3 cycles, then release → prompt=0, level=0, busy=0, seq_full=0, no pulses.
2. start at cycle 10 → level=1 at cycle 11; prompt ∈{1..4} for cycles 12–15; prompt=0 at cycles 16–17; awaiting_input=1 from cycle 18.
3. Echo the captured code as user_valid → round_pass one cycle, busy falls the next cycle. Second start → two prompts, first unchanged from round 1.
4. Echo a wrong code on element 2 → round_fail one cycle, level stays 2; retry → same two prompts replayed.
5. Give no input for 20 cycles in WAIT_INPUT → round_fail. Then user_valid in IDLE → no effect.
6. Pass 4 levels → seq_full=1, level=4; start → replay of 4 prompts, level stays 4; clear mid-SHOW_ON → IDLE next cycle, level=0, no pulses.
